// File: rtl/muldiv_unit.sv
// Iterative multiply/divide sequencer owning the architectural HI/LO registers.
// Optional macro MULDIV_FAST_MUL_EN: single-cycle multiply path (divide stays iterative).
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam int CW = $clog2(WIDTH);

    logic [1:0]         state_reg;
    logic [CW-1:0]      counter_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   opnd_reg;
    logic               is_div_reg;
    logic               neg_q_reg;
    logic               neg_r_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic               done_reg;

    // Operand magnitudes: op 0 and 2 are the signed variants.
    logic             signed_op;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    assign signed_op = ~op[0];
    assign a_abs = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_abs = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // Shift-add step: accumulator low half holds the remaining multiplier bits.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

    // Restoring divide step: upper half is the partial remainder, lower half the dividend/quotient.
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] div_next;
    assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_reg};
    assign div_ok    = ~div_diff[WIDTH+1];
    assign div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc_reg[WIDTH-2:0], div_ok};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    assign prod_fix = neg_q_reg ? (~acc_reg + 1'b1) : acc_reg;
    assign quo_fix  = neg_q_reg ? (~acc_reg[WIDTH-1:0] + 1'b1) : acc_reg[WIDTH-1:0];
    assign rem_fix  = neg_r_reg ? (~acc_reg[2*WIDTH-1:WIDTH] + 1'b1) : acc_reg[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            counter_reg <= '0;
            acc_reg     <= '0;
            opnd_reg    <= '0;
            is_div_reg  <= 1'b0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            3'd0, 3'd1: begin
                                is_div_reg <= 1'b0;
                                neg_q_reg  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_r_reg  <= signed_op & a[WIDTH-1];
`ifdef MULDIV_FAST_MUL_EN
                                acc_reg    <= fast_prod;
                                state_reg  <= S_FIX;
`else
                                acc_reg     <= {{WIDTH{1'b0}}, b_abs};
                                opnd_reg    <= a_abs;
                                counter_reg <= CW'(WIDTH - 1);
                                state_reg   <= S_RUN;
`endif
                            end
                            3'd2, 3'd3: begin
                                is_div_reg <= 1'b1;
                                if (b == '0) begin
                                    // Divide by zero: raw dividend to HI, all ones to LO, no sign fix.
                                    acc_reg   <= {a, {WIDTH{1'b1}}};
                                    neg_q_reg <= 1'b0;
                                    neg_r_reg <= 1'b0;
                                    state_reg <= S_FIX;
                                end else begin
                                    acc_reg     <= {{WIDTH{1'b0}}, a_abs};
                                    opnd_reg    <= b_abs;
                                    neg_q_reg   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                                    neg_r_reg   <= signed_op & a[WIDTH-1];
                                    counter_reg <= CW'(WIDTH - 1);
                                    state_reg   <= S_RUN;
                                end
                            end
                            3'd4:    hi_reg <= a;
                            3'd5:    lo_reg <= a;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    acc_reg     <= is_div_reg ? div_next : mul_next;
                    counter_reg <= counter_reg - 1'b1;
                    if (counter_reg == '0) begin
                        state_reg <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (is_div_reg) begin
                        hi_reg <= rem_fix;
                        lo_reg <= quo_fix;
                    end else begin
                        hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_reg <= prod_fix[WIDTH-1:0];
                    end
                    done_reg  <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy = (state_reg != S_IDLE);
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;
endmodule
